fsk_frame_ctrl: RTL

- Frame sequencer that drives the bit input of the FSK modulator.
- Accepts bytes over a valid/ready handshake and serializes each one as a frame: optional preamble, start bit, 8 data bits LSB first, optional even parity, stop bit.
- Holds each bit on mod_bit for exactly BIT_CLKS clocks, so every symbol spans an integer number of modulator tone half-periods.
- Sits between the byte source and the modulator.

---
 rtl/fsk_pkg.sv | 14 +
 rtl/fsk_bit_timer.sv | 30 +++
 rtl/fsk_frame_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fsk_pkg.sv
// Shared types and constants for the FSK frame sequencer.
package fsk_pkg;
    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        START,
        DATA,
        PARITY,
        STOP
    } fsk_frame_state_t;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/fsk_bit_timer.sv
// Clocks-per-bit counter: bit_tick marks the last clock of each transmitted bit.
module fsk_bit_timer #(
    parameter int unsigned BIT_CLKS = 256
) (
    input  logic clk,
    input  logic s_reset_n,
    input  logic clear,
    output logic bit_tick
);
    localparam int unsigned TimerW = $clog2(BIT_CLKS);

    logic [TimerW-1:0] timer_q, timer_d;

    assign bit_tick = (timer_q == TimerW'(BIT_CLKS - 1));

    always_comb begin
        timer_d = timer_q + 1'b1;
        if (clear || bit_tick) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!s_reset_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
endmodule

// File: rtl/fsk_frame_ctrl.sv
// Serializes accepted bytes into preamble/start/data/parity/stop frames for the FSK modulator.
module fsk_frame_ctrl
    import fsk_pkg::*;
#(
    parameter int unsigned BIT_CLKS      = 256,
    parameter int unsigned PREAMBLE_BITS = 8,
    parameter bit          PARITY_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       s_reset_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       mod_bit,
    output logic       busy,
    output logic       frame_done
);
    localparam int unsigned IdxW = 8;

    fsk_frame_state_t  state_q, state_d;
    logic [IdxW-1:0]   bit_idx_q, bit_idx_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              parity_q, parity_d;
    logic              mod_bit_q, mod_bit_d;
    logic              bit_tick;

    // Holding the timer clear while idle makes every frame start on a fresh bit period.
    fsk_bit_timer #(
        .BIT_CLKS (BIT_CLKS)
    ) u_bit_timer (
        .clk       (clk),
        .s_reset_n (s_reset_n),
        .clear     (state_q == IDLE),
        .bit_tick  (bit_tick)
    );

    assign mod_bit = mod_bit_q;
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        data_ready = 1'b0;
        frame_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    shreg_d   = data_in;
                    parity_d  = ^data_in;
                    bit_idx_d = '0;
                    state_d   = (PREAMBLE_BITS > 0) ? PREAMBLE : START;
                end
            end
            PREAMBLE: begin
                if (bit_tick) begin
                    if (bit_idx_q == IdxW'(PREAMBLE_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = START;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            START: begin
                if (bit_tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_idx_q == IdxW'(DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = PARITY_EN ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    frame_done = 1'b1;
                    data_ready = 1'b1;
                    if (data_valid) begin
                        // Back-to-back bytes within a burst skip the preamble.
                        shreg_d   = data_in;
                        parity_d  = ^data_in;
                        bit_idx_d = '0;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered output: derive the level the next state will present.
        unique case (state_d)
            PREAMBLE: mod_bit_d = bit_idx_d[0];
            START:    mod_bit_d = 1'b0;
            DATA:     mod_bit_d = shreg_d[0];
            PARITY:   mod_bit_d = parity_d;
            default:  mod_bit_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!s_reset_n) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            parity_q  <= 1'b0;
            mod_bit_q <= IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
            mod_bit_q <= mod_bit_d;
        end
    end
endmodule
